// File: rtl/gcm_auth_engine.sv
// GHASH/tag engine for AES-GCM: absorbs AD/CT blocks, multiplies digit-serially by H
// in GF(2^128), appends the length block and emits the tag or a tag-match flag.
module gcm_auth_engine #(
    parameter int unsigned DIGIT_W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] h_key,
    input  logic [127:0] ek_y0,
    input  logic         decrypt,
    input  logic [127:0] exp_tag,
    input  logic [127:0] blk_data,
    input  logic         blk_type,
    input  logic [4:0]   blk_bytes,
    input  logic         blk_last,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] auth_tag,
    output logic         tag_ok,
    output logic         seq_err
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned LEN_W = 64;
    localparam int unsigned M_CYC = BLK_W / DIGIT_W;
    localparam int unsigned CNT_W = (M_CYC > 1) ? $clog2(M_CYC) : 1;
    localparam logic [BLK_W-1:0] R_POLY = {8'he1, 120'h0};

    typedef enum logic [2:0] {IDLE, ACCEPT, MUL, LEN, FIN} state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] x_q, x_d, z_q, z_d, v_q, v_d, op_q, op_d;
    logic [BLK_W-1:0] h_q, h_d, ek_q, ek_d, exp_q, exp_d, tag_q, tag_d;
    logic [LEN_W-1:0] len_a_q, len_a_d, len_c_q, len_c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d, dec_q, dec_d, ct_seen_q, ct_seen_d;
    logic             seq_err_q, seq_err_d, done_q, done_d, tag_ok_q, tag_ok_d;
    logic             ready_q, ready_d, busy_q, busy_d;

    logic [BLK_W-1:0] z_step, v_step, op_step, mask_c, fin_tag_c;
    logic [4:0]       nb_c;
    logic [LEN_W-1:0] len_inc_c;
    logic             mul_end_c;

    // One digit of the shift-and-add multiply: operand bits MSB first.
    always_comb begin : digit_step
        z_step  = z_q;
        v_step  = v_q;
        op_step = op_q;
        for (int unsigned i = 0; i < DIGIT_W; i++) begin
            if (op_step[BLK_W-1]) begin
                z_step = z_step ^ v_step;
            end
            v_step  = {1'b0, v_step[BLK_W-1:1]} ^ (v_step[0] ? R_POLY : '0);
            op_step = {op_step[BLK_W-2:0], 1'b0};
        end
    end

    assign nb_c      = (blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
    assign mask_c    = ~({BLK_W{1'b1}} >> {nb_c, 3'b000});
    assign len_inc_c = LEN_W'({nb_c, 3'b000});
    assign mul_end_c = (cnt_q == CNT_W'(M_CYC - 1));
    assign fin_tag_c = z_step ^ ek_q;

    always_comb begin : next_state
        state_d   = state_q;
        x_d       = x_q;
        z_d       = z_q;
        v_d       = v_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        len_a_d   = len_a_q;
        len_c_d   = len_c_q;
        last_d    = last_q;
        ct_seen_d = ct_seen_q;
        seq_err_d = seq_err_q;
        h_d       = h_q;
        ek_d      = ek_q;
        dec_d     = dec_q;
        exp_d     = exp_q;
        tag_d     = tag_q;
        tag_ok_d  = tag_ok_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: ;
            ACCEPT: begin
                if (blk_valid) begin
                    if (!blk_type && ct_seen_q) begin
                        // Misordered AD: consumed, never absorbed, last still honoured.
                        seq_err_d = 1'b1;
                        if (blk_last) begin
                            state_d = LEN;
                            op_d    = x_q ^ {len_a_q, len_c_q};
                            v_d     = h_q;
                            z_d     = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        if (blk_type) begin
                            ct_seen_d = 1'b1;
                        end
                        if (nb_c != 5'd0) begin
                            state_d = MUL;
                            op_d    = x_q ^ (blk_data & mask_c);
                            v_d     = h_q;
                            z_d     = '0;
                            cnt_d   = '0;
                            last_d  = blk_last;
                            if (blk_type) begin
                                len_c_d = len_c_q + len_inc_c;
                            end else begin
                                len_a_d = len_a_q + len_inc_c;
                            end
                        end else if (blk_last) begin
                            state_d = LEN;
                            op_d    = x_q ^ {len_a_q, len_c_q};
                            v_d     = h_q;
                            z_d     = '0;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            MUL: begin
                z_d   = z_step;
                v_d   = v_step;
                op_d  = op_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_end_c) begin
                    x_d = z_step;
                    if (last_q) begin
                        state_d = LEN;
                        op_d    = z_step ^ {len_a_q, len_c_q};
                        v_d     = h_q;
                        z_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            LEN: begin
                z_d   = z_step;
                v_d   = v_step;
                op_d  = op_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_end_c) begin
                    x_d      = z_step;
                    tag_d    = fin_tag_c;
                    tag_ok_d = dec_q && (fin_tag_c == exp_q);
                    done_d   = 1'b1;
                    state_d  = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Start aborts whatever is in flight, including a coincident block.
        if (start) begin
            state_d   = ACCEPT;
            x_d       = '0;
            len_a_d   = '0;
            len_c_d   = '0;
            last_d    = 1'b0;
            ct_seen_d = 1'b0;
            seq_err_d = 1'b0;
            h_d       = h_key;
            ek_d      = ek_y0;
            dec_d     = decrypt;
            exp_d     = exp_tag;
            tag_d     = tag_q;
            tag_ok_d  = tag_ok_q;
            done_d    = 1'b0;
        end

        ready_d = (state_d == ACCEPT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            z_q       <= '0;
            v_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            len_a_q   <= '0;
            len_c_q   <= '0;
            last_q    <= 1'b0;
            ct_seen_q <= 1'b0;
            seq_err_q <= 1'b0;
            h_q       <= '0;
            ek_q      <= '0;
            dec_q     <= 1'b0;
            exp_q     <= '0;
            tag_q     <= '0;
            tag_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            z_q       <= z_d;
            v_q       <= v_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            len_a_q   <= len_a_d;
            len_c_q   <= len_c_d;
            last_q    <= last_d;
            ct_seen_q <= ct_seen_d;
            seq_err_q <= seq_err_d;
            h_q       <= h_d;
            ek_q      <= ek_d;
            dec_q     <= dec_d;
            exp_q     <= exp_d;
            tag_q     <= tag_d;
            tag_ok_q  <= tag_ok_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign blk_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign auth_tag  = tag_q;
    assign tag_ok    = tag_ok_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_gcm_auth_engine.sv
// Scoreboard bench for gcm_auth_engine: two instances (DIGIT_W=1 and 8) driven by
// directed NIST cases and random messages, checked against a GHASH reference model.
module tb_gcm_auth_engine;
    localparam int DW0 = 1;
    localparam int DW1 = 8;
    localparam logic [127:0] R_POLY  = {8'he1, 120'h0};
    localparam logic [127:0] NIST_H  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] NIST_EK = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] NIST_C  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] NIST_T2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

    typedef struct {
        logic [127:0] tag;
        logic         ok;
        logic         serr;
        longint       cyc;
        int           tc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    longint       cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    logic         start     [2];
    logic [127:0] h_key     [2];
    logic [127:0] ek_y0     [2];
    logic         decrypt   [2];
    logic [127:0] exp_tag   [2];
    logic [127:0] blk_data  [2];
    logic         blk_type  [2];
    logic [4:0]   blk_bytes [2];
    logic         blk_last  [2];
    logic         blk_valid [2];
    logic         blk_ready [2];
    logic         busy      [2];
    logic         done      [2];
    logic [127:0] auth_tag  [2];
    logic         tag_ok    [2];
    logic         seq_err   [2];

    exp_t         q0[$];
    exp_t         q1[$];

    logic [127:0] m_data[$];
    bit           m_type[$];
    logic [4:0]   m_bytes[$];
    bit           m_abs[$];

    gcm_auth_engine #(.DIGIT_W(DW0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .h_key(h_key[0]), .ek_y0(ek_y0[0]),
        .decrypt(decrypt[0]), .exp_tag(exp_tag[0]), .blk_data(blk_data[0]),
        .blk_type(blk_type[0]), .blk_bytes(blk_bytes[0]), .blk_last(blk_last[0]),
        .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .busy(busy[0]), .done(done[0]),
        .auth_tag(auth_tag[0]), .tag_ok(tag_ok[0]), .seq_err(seq_err[0])
    );

    gcm_auth_engine #(.DIGIT_W(DW1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .h_key(h_key[1]), .ek_y0(ek_y0[1]),
        .decrypt(decrypt[1]), .exp_tag(exp_tag[1]), .blk_data(blk_data[1]),
        .blk_type(blk_type[1]), .blk_bytes(blk_bytes[1]), .blk_last(blk_last[1]),
        .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .busy(busy[1]), .done(done[1]),
        .auth_tag(auth_tag[1]), .tag_ok(tag_ok[1]), .seq_err(seq_err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input int d, input logic [127:0] act,
                                  input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, required %h", nm, d, act, req);
        end
    endfunction

    function automatic void check_bit(input string nm, input int d, input logic act,
                                      input logic req);
        check(nm, d, 128'(act), 128'(req));
    endfunction

    function automatic void fail_now(input string nm, input int d);
        n_checks++;
        n_fail++;
        $display("FAIL %s dut%0d: bound expired, required the event within budget", nm, d);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_pop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void q_push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // GF(2^128) product in GCM bit order (bit 127 is the coefficient of x^0).
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] z = '0;
        logic [127:0] v = b;
        for (int i = 127; i >= 0; i--) begin
            if (a[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
        end
        return z;
    endfunction

    // GHASH over the queued message under the engine's block rules.
    task automatic model_msg(input logic [127:0] h, output logic [127:0] x,
                             output bit serr, output bit abs_last);
        logic [63:0]  la, lc;
        logic [127:0] blk;
        bit           ct;
        int           nb;
        x = '0; la = '0; lc = '0; ct = 0; serr = 0;
        m_abs.delete();
        for (int i = 0; i < m_data.size(); i++) begin
            nb = (m_bytes[i] > 5'd16) ? 16 : int'(m_bytes[i]);
            if (!m_type[i] && ct) begin
                serr = 1;
                m_abs.push_back(0);
            end else begin
                if (m_type[i]) ct = 1;
                if (nb == 0) begin
                    m_abs.push_back(0);
                end else begin
                    blk = '0;
                    for (int k = 0; k < nb; k++) blk[127-8*k -: 8] = m_data[i][127-8*k -: 8];
                    x = gf_mul(x ^ blk, h);
                    if (m_type[i]) lc = lc + 64'(8 * nb);
                    else la = la + 64'(8 * nb);
                    m_abs.push_back(1);
                end
            end
        end
        abs_last = m_abs[m_abs.size()-1];
        x = gf_mul(x ^ {la, lc}, h);
    endtask

    task automatic clear_msg();
        m_data.delete();
        m_type.delete();
        m_bytes.delete();
    endtask

    task automatic add_blk(input logic [127:0] data, input bit typ, input logic [4:0] nb);
        m_data.push_back(data);
        m_type.push_back(typ);
        m_bytes.push_back(nb);
    endtask

    function automatic logic [4:0] rnd_bytes();
        if ($urandom_range(0, 9) == 0) return 5'd0;
        return 5'($urandom_range(1, 20));
    endfunction

    task automatic build_random();
        int n_ad, n_ct;
        clear_msg();
        n_ad = int'($urandom_range(0, 2));
        n_ct = int'($urandom_range(0, 3));
        for (int i = 0; i < n_ad; i++) add_blk(rand128(), 1'b0, rnd_bytes());
        for (int i = 0; i < n_ct; i++) add_blk(rand128(), 1'b1, rnd_bytes());
        if (n_ct > 0 && $urandom_range(0, 3) == 0) add_blk(rand128(), 1'b0, rnd_bytes());
        if (m_data.size() == 0 || $urandom_range(0, 3) == 0)
            add_blk(rand128(), 1'($urandom_range(0, 1)), 5'd0);
    endtask

    // exp_sel: 0 = correct tag, 1 = tag with bit 0 flipped, else random.
    task automatic run_msg(input int d, input logic [127:0] h, input logic [127:0] ek,
                           input bit dec, input int exp_sel, input bit use_force,
                           input logic [127:0] force_tag, input int tc);
        logic [127:0] x, tag, expv;
        bit           serr, abs_last, prev_abs, ok;
        longint       t, prev_t;
        int           m;
        exp_t         e;
        model_msg(h, x, serr, abs_last);
        tag  = use_force ? force_tag : (x ^ ek);
        expv = (exp_sel == 0) ? tag : (exp_sel == 1) ? (tag ^ 128'd1) : rand128();
        m    = 128 / ((d == 0) ? DW0 : DW1);
        t = 0; prev_t = 0; prev_abs = 0;

        start[d] = 1'b1; h_key[d] = h; ek_y0[d] = ek; decrypt[d] = dec; exp_tag[d] = expv;
        @(negedge clk);
        start[d] = 1'b0; h_key[d] = rand128(); ek_y0[d] = rand128();
        exp_tag[d] = rand128(); decrypt[d] = ~dec;

        for (int i = 0; i < m_data.size(); i++) begin
            blk_data[d]  = m_data[i];
            blk_type[d]  = m_type[i];
            blk_bytes[d] = m_bytes[i];
            blk_last[d]  = (i == m_data.size() - 1);
            blk_valid[d] = 1'b1;
            ok = 0;
            for (int k = 0; k < 4 * m + 20; k++) begin
                if (blk_ready[d]) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                fail_now("blk_ready_wait", d);
                blk_valid[d] = 1'b0;
                return;
            end
            t = cyc + 1;
            if (i > 0)
                check("blk_spacing", d, 128'(t), 128'(prev_abs ? prev_t + m + 1 : prev_t + 1));
            prev_t   = t;
            prev_abs = m_abs[i];
            @(negedge clk);
        end
        blk_valid[d] = 1'b0;
        blk_last[d]  = 1'b0;

        e = '{tag: tag, ok: dec && (tag == expv), serr: serr,
              cyc: t + (abs_last ? 2 * m : m), tc: tc};
        q_push(d, e);
        for (int k = 0; k < 4 * m + 20 && q_size(d) != 0; k++) @(negedge clk);
        if (q_size(d) != 0) begin
            fail_now("done_wait", d);
            void'(q_pop(d));
        end
        @(negedge clk);
        check_bit("idle_busy", d, busy[d], 1'b0);
        check_bit("idle_ready", d, blk_ready[d], 1'b0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending message.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!reset && done[d]) begin
                if (q_size(d) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done dut%0d: got done=1 at edge %0d, required no done",
                             d, cyc);
                end else begin
                    e = q_pop(d);
                    check($sformatf("auth_tag_tc%0d", e.tc), d, auth_tag[d], e.tag);
                    check_bit($sformatf("tag_ok_tc%0d", e.tc), d, tag_ok[d], e.ok);
                    check_bit($sformatf("seq_err_tc%0d", e.tc), d, seq_err[d], e.serr);
                    check_bit($sformatf("busy_fin_tc%0d", e.tc), d, busy[d], 1'b1);
                    check($sformatf("done_cycle_tc%0d", e.tc), d, 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    task automatic check_reset_outputs(input int d);
        check_bit("rst_blk_ready", d, blk_ready[d], 1'b0);
        check_bit("rst_busy", d, busy[d], 1'b0);
        check_bit("rst_done", d, done[d], 1'b0);
        check("rst_auth_tag", d, auth_tag[d], 128'd0);
        check_bit("rst_tag_ok", d, tag_ok[d], 1'b0);
        check_bit("rst_seq_err", d, seq_err[d], 1'b0);
    endtask

    initial begin
        int m;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; h_key[d] = '0; ek_y0[d] = '0; decrypt[d] = 1'b0;
            exp_tag[d] = '0; blk_data[d] = '0; blk_type[d] = 1'b0; blk_bytes[d] = '0;
            blk_last[d] = 1'b0; blk_valid[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset_outputs(d);
        reset = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            m = 128 / ((d == 0) ? DW0 : DW1);

            clear_msg(); add_blk(128'd0, 1'b1, 5'd0);
            run_msg(d, NIST_H, NIST_EK, 1'b0, 0, 1'b1, NIST_EK, 1);

            clear_msg(); add_blk(NIST_C, 1'b1, 5'd16);
            run_msg(d, NIST_H, NIST_EK, 1'b0, 0, 1'b1, NIST_T2, 2);
            run_msg(d, NIST_H, NIST_EK, 1'b1, 0, 1'b1, NIST_T2, 3);
            run_msg(d, NIST_H, NIST_EK, 1'b1, 1, 1'b1, NIST_T2, 4);

            clear_msg();
            add_blk(rand128(), 1'b0, 5'd16);
            add_blk(rand128(), 1'b1, 5'd16);
            add_blk(rand128(), 1'b0, 5'd16);
            run_msg(d, rand128(), rand128(), 1'b0, 0, 1'b0, '0, 5);

            clear_msg(); add_blk(rand128() | 128'd1, 1'b1, 5'd5);
            run_msg(d, rand128(), rand128(), 1'b0, 0, 1'b0, '0, 6);

            clear_msg(); add_blk(rand128(), 1'b0, 5'd16); add_blk(rand128(), 1'b1, 5'd19);
            run_msg(d, rand128(), rand128(), 1'b1, 0, 1'b0, '0, 7);

            for (int r = 0; r < 10; r++) begin
                build_random();
                run_msg(d, rand128(), rand128(), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 2)), 1'b0, '0, 100 + r);
            end

            // Abort a multiply with reset, then confirm a clean re-run.
            start[d] = 1'b1; h_key[d] = NIST_H; ek_y0[d] = NIST_EK; decrypt[d] = 1'b0;
            @(negedge clk);
            start[d] = 1'b0;
            blk_data[d] = NIST_C; blk_type[d] = 1'b1; blk_bytes[d] = 5'd16;
            blk_last[d] = 1'b1; blk_valid[d] = 1'b1;
            @(negedge clk);
            blk_valid[d] = 1'b0; blk_last[d] = 1'b0;
            repeat (3) @(negedge clk);
            check_bit("mid_mul_busy", d, busy[d], 1'b1);
            reset = 1'b1;
            #1;
            check_reset_outputs(d);
            @(negedge clk);
            reset = 1'b0;
            repeat (3 * m + 4) @(negedge clk);
            clear_msg(); add_blk(NIST_C, 1'b1, 5'd16);
            run_msg(d, NIST_H, NIST_EK, 1'b1, 0, 1'b1, NIST_T2, 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
